// File: rtl/hack_pkg.sv
// Shared CPU-core constants and the program-counter operation encoding.
package hack_pkg;

  localparam int          PC_WIDTH    = 16;
  localparam logic [15:0] RESET_ADDR  = 16'h0000;
  localparam logic [15:0] TRAP_VECTOR = 16'h7FF0;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_LOAD,
    PC_CALL,
    PC_RET
  } pc_op_t;

endpackage

// File: rtl/lifo_stack.sv
// Generic LIFO of DEPTH entries with occupancy count; push is ignored when full, pop when empty.
module lifo_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && !pop_i && (count_q != CW'(DEPTH));
  assign pop_ok  = pop_i && (count_q != '0);
  assign wr_idx  = AW'(count_q);
  assign rd_idx  = AW'(count_q - CW'(1));
  assign rdata_o = mem_q[rd_idx];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (push_ok)     count_d = count_q + CW'(1);
    else if (pop_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // NOTE: the storage array has no reset; only count_q defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_idx] <= wdata_i;
  end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with hardware return-address stack and sticky fault flags.
// Optional build macro PC_TRAP_EN: stack faults redirect the PC to TRAP_VECTOR.
module pc_call_stack #(
  parameter int               WIDTH       = hack_pkg::PC_WIDTH,
  parameter int               DEPTH       = 8,
  parameter logic [WIDTH-1:0] RESET_ADDR  = WIDTH'(hack_pkg::RESET_ADDR)
`ifdef PC_TRAP_EN
  , parameter logic [WIDTH-1:0] TRAP_VECTOR = WIDTH'(hack_pkg::TRAP_VECTOR)
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic                       inc,
  input  logic                       call,
  input  logic                       ret,
  input  logic                       clr_err,
  input  logic [WIDTH-1:0]           data,
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       underflow
);

  import hack_pkg::*;

  localparam int SPW = $clog2(DEPTH+1);

  pc_op_t           op;
  logic [WIDTH-1:0] pc_q, pc_d, pc_inc, top_addr;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             push, pop;
  logic [SPW-1:0]   count;

  assign pc_inc = pc_q + WIDTH'(1);

  // Fixed priority: ret > call > load > inc; anything below the winner is dropped.
  always_comb begin
    op = PC_HOLD;
    if (ret)       op = PC_RET;
    else if (call) op = PC_CALL;
    else if (load) op = PC_LOAD;
    else if (inc)  op = PC_INC;
  end

  // NOTE: every output of this block is defaulted up front so no path infers a latch.
  always_comb begin
    pc_d  = pc_q;
    ovf_d = clr_err ? 1'b0 : ovf_q;
    unf_d = clr_err ? 1'b0 : unf_q;
    push  = 1'b0;
    pop   = 1'b0;
    unique case (op)
      PC_INC:  pc_d = pc_inc;
      PC_LOAD: pc_d = data;
      PC_CALL: begin
        if (!full) begin
          push = 1'b1;
          pc_d = data;
        end else begin
          ovf_d = 1'b1;
`ifdef PC_TRAP_EN
          pc_d  = TRAP_VECTOR;
`else
          pc_d  = data;
`endif
        end
      end
      PC_RET: begin
        if (!empty) begin
          pop  = 1'b1;
          pc_d = top_addr;
        end else begin
          unf_d = 1'b1;
`ifdef PC_TRAP_EN
          pc_d  = TRAP_VECTOR;
`endif
        end
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments; reset is synchronous and wins over all requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_ADDR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  lifo_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (pc_inc),
    .rdata_o (top_addr),
    .count_o (count)
  );

  assign out       = pc_q;
  assign sp        = count;
  assign full      = (count == SPW'(DEPTH));
  assign empty     = (count == '0);
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// Directed plus random checking of pc_call_stack against a queue-based reference model.
module tb_pc_call_stack;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset, load, inc, call, ret, clr_err;
  logic [15:0] data;
  logic [15:0] out;
  logic [3:0]  sp;
  logic        full, empty, overflow, underflow;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [15:0] m_pc;
  logic [15:0] m_stack[$];
  bit          m_ovf, m_unf;

  pc_call_stack #(.WIDTH(16), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .inc       (inc),
    .call      (call),
    .ret       (ret),
    .clr_err   (clr_err),
    .data      (data),
    .out       (out),
    .sp        (sp),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rs, input bit ld, input bit in, input bit ca,
                            input bit rt, input bit ce, input logic [15:0] d);
    if (rs) begin
      m_pc = 16'h0000;
      m_stack.delete();
      m_ovf = 0;
      m_unf = 0;
      return;
    end
    if (ce) begin
      m_ovf = 0;
      m_unf = 0;
    end
    if (rt) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else begin
        m_unf = 1;
`ifdef PC_TRAP_EN
        m_pc = 16'h7FF0;
`endif
      end
    end else if (ca) begin
      if (m_stack.size() < DEPTH) begin
        m_stack.push_back(m_pc + 16'd1);
        m_pc = d;
      end else begin
        m_ovf = 1;
`ifdef PC_TRAP_EN
        m_pc = 16'h7FF0;
`else
        m_pc = d;
`endif
      end
    end else if (ld) m_pc = d;
    else if (in) m_pc = m_pc + 16'd1;
  endtask

  // Apply one cycle of requests, advance the model, and compare every output.
  task automatic step(input string tag, input bit rs, input bit ld, input bit in, input bit ca,
                      input bit rt, input bit ce, input logic [15:0] d);
    reset = rs; load = ld; inc = in; call = ca; ret = rt; clr_err = ce; data = d;
    @(posedge clk);
    model_step(rs, ld, in, ca, rt, ce, d);
    #1;
    reset = 0; load = 0; inc = 0; call = 0; ret = 0; clr_err = 0;
    check({tag, ".out"},   32'(out),       32'(m_pc));
    check({tag, ".sp"},    32'(sp),        32'(m_stack.size()));
    check({tag, ".full"},  32'(full),      32'(m_stack.size() == DEPTH));
    check({tag, ".empty"}, 32'(empty),     32'(m_stack.size() == 0));
    check({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
    check({tag, ".unf"},   32'(underflow), 32'(m_unf));
  endtask

  initial begin
    reset = 1; load = 0; inc = 0; call = 0; ret = 0; clr_err = 0; data = '0;
    m_pc = '0; m_ovf = 0; m_unf = 0;
    #2;

    // 1: reset, three increments, hold
    step("rst",  1, 0, 0, 0, 0, 0, 16'h0);
    step("rst2", 1, 0, 1, 1, 0, 0, 16'h1234);
    check("rst.out_const", 32'(out), 32'h0);
    step("inc1", 0, 0, 1, 0, 0, 0, 16'h0);
    step("inc2", 0, 0, 1, 0, 0, 0, 16'h0);
    step("inc3", 0, 0, 1, 0, 0, 0, 16'h0);
    check("inc3.out_const", 32'(out), 32'h3);
    step("hold", 0, 0, 0, 0, 0, 0, 16'h0);

    // 2: single call / return
    step("ld10",  0, 1, 0, 0, 0, 0, 16'h0010);
    step("call1", 0, 0, 0, 1, 0, 0, 16'h0200);
    check("call1.out_const", 32'(out), 32'h0200);
    step("ret1",  0, 0, 0, 0, 1, 0, 16'h0);
    check("ret1.out_const", 32'(out), 32'h0011);

    // 3: fill, overflow, unwind in LIFO order
    for (int i = 0; i < DEPTH; i++) step("nest", 0, 0, 0, 1, 0, 0, 16'h0100 + 16'(i * 16));
    step("ovf", 0, 0, 0, 1, 0, 0, 16'h0300);
`ifdef PC_TRAP_EN
    check("ovf.out_const", 32'(out), 32'h7FF0);
`else
    check("ovf.out_const", 32'(out), 32'h0300);
`endif
    for (int i = 0; i < DEPTH; i++) step("unwind", 0, 0, 0, 0, 1, 0, 16'h0);
    check("unwind.last", 32'(out), 32'h0012);

    // 4: underflow, clear with simultaneous fault, then clear
    step("unf",     0, 0, 0, 0, 1, 0, 16'h0);
    step("clr_ret", 0, 0, 0, 0, 1, 1, 16'h0);
    step("clr",     0, 0, 0, 0, 0, 1, 16'h0);
    check("clr.unf_const", 32'(underflow), 32'h0);

    // 5: wrap on inc and on pushed return address
    step("ldff",   0, 1, 0, 0, 0, 0, 16'hFFFF);
    step("wrap",   0, 0, 1, 0, 0, 0, 16'h0);
    step("ldff2",  0, 1, 0, 0, 0, 0, 16'hFFFF);
    step("callff", 0, 0, 0, 1, 0, 0, 16'h0040);
    step("retff",  0, 0, 0, 0, 1, 0, 16'h0);
    check("retff.out_const", 32'(out), 32'h0);

    // 6: everything at once with sp=1, then reset mid-sequence
    step("call6", 0, 0, 0, 1, 0, 0, 16'h0500);
    step("all",   0, 1, 1, 1, 1, 0, 16'h0777);
    step("callA", 0, 0, 0, 1, 0, 0, 16'h0600);
    step("callB", 0, 0, 0, 1, 0, 0, 16'h0700);
    step("ret_e", 0, 0, 0, 0, 1, 0, 16'h0);
    step("ret_e", 0, 0, 0, 0, 1, 0, 16'h0);
    step("ret_u", 0, 0, 0, 0, 1, 0, 16'h0);
    step("callC", 0, 0, 0, 1, 0, 0, 16'h0800);
    step("rst6",  1, 0, 0, 1, 0, 0, 16'h0900);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      step("rnd", (r == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
           (r > 55), (r > 30 && r <= 55) || ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 19) == 0), 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
